apb_regfile_slave: RTL and testbench
====================================

Name: apb_regfile_slave

Overview:
- APB4 completer that sits on the slave-side signal set of the shared APB interface: samples paddr/psel/penable/pwrite/pwdata/pstrb/pprot and drives pready/prdata/pslverr.
- Holds a bank of NUM_REGS read/write registers with byte-strobe writes and programmable wait states.
- Flags an error for out-of-range or misaligned accesses.
- Acts as the reference target for master-agent and passive-monitor verification.

Parameters:
- PM, apb_parameter, struct of type apb_parameter_t with ADDR_WIDTH (default 32) and DATA_WIDTH (default 32; allowed values 8, 16, 32, 64).
- NUM_REGS, 16, number of DATA_WIDTH-bit registers; must be at least 1.
- WAIT_STATES, 0, number of access-phase cycles with pready low before completion; allowed range 0..15.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- paddr  in  PM.ADDR_WIDTH  byte address.
- pprot  in  1  protection attribute; accepted and ignored.
- psel  in  1  slave select.
- penable  in  1  access phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  PM.DATA_WIDTH  write data.
- pstrb  in  PM.DATA_WIDTH/8  write byte strobes.
- pready  out  1  transfer complete.
- prdata  out  PM.DATA_WIDTH  read data.
- pslverr  out  1  error response.

Behaviour:
- Transfer phases:
  - Setup phase: psel=1, penable=0.
  - Access phase: psel=1, penable=1.
  - penable=1 with psel=0 is ignored; no state change.
- Wait-state counter:
  - Registered counter wcnt, width 4.
  - wcnt increments each access-phase cycle while wcnt < WAIT_STATES.
  - wcnt clears to 0 on reset, on completion, and whenever psel=0 or penable=0.
- pready is combinational: psel & penable & (wcnt == WAIT_STATES).
  - WAIT_STATES=0 gives zero-wait completion in the first access cycle.
  - WAIT_STATES=N holds pready low for exactly N access cycles and asserts it in cycle N+1.
- Address decode:
  - LSB = log2(DATA_WIDTH/8).
  - idx = paddr >> LSB.
  - Error condition err = (paddr[LSB-1:0] != 0) | (idx >= NUM_REGS).
- pslverr = pready & err, combinational; low at all other times.
- Write commit occurs on the rising edge where pready & pwrite & !err.
  - For each byte b with pstrb[b]=1, reg[idx][8b+7:8b] <= pwdata byte b.
  - Bytes with pstrb[b]=0 keep their value.
  - pstrb=0 is a legal no-op write that completes without error.
- Read: prdata = reg[idx] when pready & !pwrite & !err; otherwise prdata = 0.
- Error transfers never modify any register. An erroring read returns prdata = 0.
- Back-to-back transfers are legal: a new setup phase may follow immediately on the cycle after completion.
- Master changes of paddr/pwrite during a wait state are not supported. The slave uses the current values; no checking is required.
- Reset values (synchronous, active-high):
  - All registers = 0.
  - wcnt = 0.
  - Because psel is externally low during reset: pready = 0, prdata = 0, pslverr = 0.
- Reset asserted mid-transfer aborts the transfer: wcnt clears and the registers clear. A write coinciding with reset is lost; reset has priority.

Decomposition:
- Shared package apb_pkg holds:
  - typedef apb_parameter_t (ADDR_WIDTH, DATA_WIDTH).
  - Default constant apb_parameter (32, 32).
  - Response encoding constants APB_OKAY=0 and APB_ERR=1 for pslverr.
- One natural sub-module, apb_wait_ctrl: holds the wcnt counter and pready generation.
- Register bank, decode and strobe logic stay in the top level.

Test Plan:
- Reset then read of address 0x00 (WAIT_STATES=0): pready=1 in the first access cycle; prdata=0x00000000; pslverr=0.
- Write 0xDEADBEEF to 0x08 with pstrb=0xF, then read 0x08: prdata=0xDEADBEEF. Then write 0x11223344 with pstrb=0x5 and read 0x08: prdata=0xDE22BE44.
- WAIT_STATES=3, read 0x04: pready low for exactly 3 access cycles and high in the 4th; prdata is valid only in the 4th cycle.
- Write to 0x40 (idx 16, with NUM_REGS=16) and write to misaligned 0x02: pslverr=1 together with pready; all registers unchanged; an erroring read returns prdata=0.
- Back-to-back writes to 0x00, 0x04, 0x08 with no idle cycles, then readback: all three values correct; no spurious pready between transfers.
- Reset asserted during the wait state of a write to 0x0C (WAIT_STATES=2): pready never asserts for that transfer; a later read of 0x0C returns 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus parameter struct, its default, response encoding
// and the address-decode helper used by APB completers.
package apb_pkg;

    typedef struct packed {
        int unsigned ADDR_WIDTH;
        int unsigned DATA_WIDTH;
    } apb_parameter_t;

    localparam apb_parameter_t apb_parameter = '{ADDR_WIDTH: 32'd32, DATA_WIDTH: 32'd32};

    // pslverr encoding
    localparam logic APB_OKAY = 1'b0;
    localparam logic APB_ERR  = 1'b1;

    // Number of byte-offset address bits below the word index for a given data width.
    function automatic int unsigned apb_lsb(input int unsigned data_width);
        return $clog2(data_width / 32'd8);
    endfunction

endpackage

// File: rtl/apb_if.sv
// APB4 signal bundle with requester (master) and completer (slave) views.
interface apb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_wait_ctrl.sv
// Access-phase wait-state counter and pready generation for an APB completer.
// pready rises once the access phase has lasted WAIT_STATES cycles.
module apb_wait_ctrl #(
    parameter int WAIT_STATES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_psel,
    input  logic i_penable,
    output logic o_pready
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [3:0] r_wcnt;
    logic       w_access;

    assign w_access = i_psel & i_penable;
    assign o_pready = w_access & (r_wcnt == WS);

    // Count access-phase cycles; restart on idle, setup, completion or reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wcnt <= 4'd0;
        end else if (!w_access || o_pready) begin
            r_wcnt <= 4'd0;
        end else if (r_wcnt < WS) begin
            r_wcnt <= r_wcnt + 4'd1;
        end else begin
            r_wcnt <= r_wcnt;
        end
    end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB4 completer holding NUM_REGS data-width registers with byte-strobe writes,
// programmable wait states and an error response for misaligned or
// out-of-range addresses. pprot is accepted but has no effect.
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter apb_parameter_t PM          = apb_parameter,
    parameter int             NUM_REGS    = 16,
    parameter int             WAIT_STATES = 0
) (
    input  logic clk,
    input  logic reset,
    apb_if.slave bus
);

    localparam int AW    = int'(PM.ADDR_WIDTH);
    localparam int DW    = int'(PM.DATA_WIDTH);
    localparam int SW    = DW / 8;
    localparam int LSB   = int'(apb_lsb(PM.DATA_WIDTH));
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [AW-1:0] ADDR_MASK = AW'((64'd1 << LSB) - 64'd1);
    localparam logic [AW-1:0] REG_LIMIT = AW'(NUM_REGS);

    logic [DW-1:0]    r_regs [NUM_REGS];
    logic [AW-1:0]    w_idx_full;
    logic [IDX_W-1:0] w_idx;
    logic             w_err;
    logic             w_pready;
    logic             w_wr_en;
    logic [DW-1:0]    w_prdata;
    logic             w_unused_ok;

    apb_wait_ctrl #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_ctrl (
        .clk       (clk),
        .reset     (reset),
        .i_psel    (bus.psel),
        .i_penable (bus.penable),
        .o_pready  (w_pready)
    );

    // Word index and error decode; the truncated index is only used when in range.
    assign w_idx_full  = bus.paddr >> LSB;
    assign w_idx       = w_idx_full[IDX_W-1:0];
    assign w_err       = ((bus.paddr & ADDR_MASK) != '0) | (w_idx_full >= REG_LIMIT);
    assign w_wr_en     = w_pready & bus.pwrite & ~w_err;
    assign w_unused_ok = bus.pprot;

    // Register bank: cleared by reset, otherwise byte-wise update on a good write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            for (int b = 0; b < SW; b++) begin
                if (bus.pstrb[b]) begin
                    r_regs[w_idx][8*b +: 8] <= bus.pwdata[8*b +: 8];
                end
            end
        end
    end

    // Read data is driven only on a completing, error-free read.
    always_comb begin
        w_prdata = '0;
        if (w_pready && !bus.pwrite && !w_err) begin
            w_prdata = r_regs[w_idx];
        end else begin
            w_prdata = '0;
        end
    end

    assign bus.pready  = w_pready;
    assign bus.prdata  = w_prdata;
    assign bus.pslverr = (w_pready && w_err) ? APB_ERR : APB_OKAY;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench for apb_regfile_slave: three instances (0, 3 and 2 wait
// states) share one driven master bus, with psel routed to the selected target.
// The driver pushes the expected completion; the monitor pops and checks it.
module tb_apb_regfile_slave;
    import apb_pkg::*;

    typedef struct {
        int          tgt;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [31:0] m_paddr   = 32'd0;
    logic        m_pprot   = 1'b0;
    logic        m_psel    = 1'b0;
    logic        m_penable = 1'b0;
    logic        m_pwrite  = 1'b0;
    logic [31:0] m_pwdata  = 32'd0;
    logic [3:0]  m_pstrb   = 4'd0;
    int          m_tgt     = 0;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    logic [2:0]  pr;
    logic [31:0] rd [3];
    logic        er [3];

    always #5 clk = ~clk;

    apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
    apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

    assign bus0.paddr = m_paddr;  assign bus1.paddr = m_paddr;  assign bus2.paddr = m_paddr;
    assign bus0.pprot = m_pprot;  assign bus1.pprot = m_pprot;  assign bus2.pprot = m_pprot;
    assign bus0.penable = m_penable; assign bus1.penable = m_penable; assign bus2.penable = m_penable;
    assign bus0.pwrite = m_pwrite; assign bus1.pwrite = m_pwrite; assign bus2.pwrite = m_pwrite;
    assign bus0.pwdata = m_pwdata; assign bus1.pwdata = m_pwdata; assign bus2.pwdata = m_pwdata;
    assign bus0.pstrb = m_pstrb;  assign bus1.pstrb = m_pstrb;  assign bus2.pstrb = m_pstrb;
    assign bus0.psel = m_psel && (m_tgt == 0);
    assign bus1.psel = m_psel && (m_tgt == 1);
    assign bus2.psel = m_psel && (m_tgt == 2);

    assign pr = {bus2.pready, bus1.pready, bus0.pready};
    assign rd[0] = bus0.prdata; assign rd[1] = bus1.prdata; assign rd[2] = bus2.prdata;
    assign er[0] = bus0.pslverr; assign er[1] = bus1.pslverr; assign er[2] = bus2.pslverr;

    apb_regfile_slave #(.PM(apb_parameter), .NUM_REGS(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    apb_regfile_slave #(.PM(apb_parameter), .NUM_REGS(16), .WAIT_STATES(3)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));
    apb_regfile_slave #(.PM(apb_parameter), .NUM_REGS(16), .WAIT_STATES(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2));

    // Monitor: checks every completion against the scoreboard, quiet outputs during waits.
    initial begin
        int   acc_cnt;
        int   tg;
        exp_t e;
        acc_cnt = 0;
        forever begin
            @(negedge clk);
            if (pr != 3'b000) begin
                tg = pr[0] ? 0 : (pr[1] ? 1 : 2);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_pready: dut=%0d pready seen with no transfer expected", tg);
                end else begin
                    e = exp_q.pop_front();
                    if (tg != e.tgt || rd[tg] !== e.rdata || er[tg] !== e.err || acc_cnt != e.waits) begin
                        bad++;
                        $display("FAIL completion: got dut=%0d prdata=%h pslverr=%b waits=%0d, want dut=%0d prdata=%h pslverr=%b waits=%0d",
                                 tg, rd[tg], er[tg], acc_cnt, e.tgt, e.rdata, e.err, e.waits);
                    end
                end
                acc_cnt = 0;
            end else if (reset) begin
                acc_cnt = 0;
            end else if (m_psel && m_penable) begin
                total++;
                if (rd[m_tgt] !== 32'd0 || er[m_tgt] !== 1'b0) begin
                    bad++;
                    $display("FAIL wait_quiet: dut=%0d prdata=%h pslverr=%b, want 0/0", m_tgt, rd[m_tgt], er[m_tgt]);
                end
                acc_cnt++;
            end else begin
                acc_cnt = 0;
            end
        end
    end

    // One APB transfer, entered just after a rising edge; leaves the bus in access phase.
    task automatic xfer(input int tgt, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] exp_rd, input logic exp_err, input int waits);
        exp_t e;
        bit   done;
        e.tgt = tgt; e.rdata = exp_rd; e.err = exp_err; e.waits = waits;
        exp_q.push_back(e);
        m_tgt = tgt; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr;
        m_paddr = addr; m_pwdata = wdata; m_pstrb = strb;
        @(posedge clk); #1;
        m_penable = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (pr[tgt]) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout: dut=%0d addr=%h no pready within 40 cycles", tgt, addr);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic idle();
        m_psel = 1'b0; m_penable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input int tgt, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic err, input int w);
        xfer(tgt, 1'b1, a, d, s, 32'd0, err, w);
    endtask

    task automatic rdc(input int tgt, input logic [31:0] a, input logic [31:0] exp,
                       input logic err, input int w);
        xfer(tgt, 1'b0, a, 32'd0, 4'd0, exp, err, w);
    endtask

    // Directed stimulus.
    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (pr[k] !== 1'b0 || rd[k] !== 32'd0 || er[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs: dut=%0d pready=%b prdata=%h pslverr=%b, want 0/0/0", k, pr[k], rd[k], er[k]);
            end
        end
        @(posedge clk); #1;

        // Zero wait states: reset value, full and partial strobe writes.
        rdc(0, 32'h00, 32'h0000_0000, 1'b0, 0);
        wr (0, 32'h08, 32'hDEAD_BEEF, 4'hF, 1'b0, 0);
        rdc(0, 32'h08, 32'hDEAD_BEEF, 1'b0, 0);
        wr (0, 32'h08, 32'h1122_3344, 4'h5, 1'b0, 0);
        rdc(0, 32'h08, 32'hDE22_BE44, 1'b0, 0);
        wr (0, 32'h08, 32'hFFFF_FFFF, 4'h0, 1'b0, 0);
        rdc(0, 32'h08, 32'hDE22_BE44, 1'b0, 0);
        idle();

        // Errors: out of range, misaligned; nothing may change.
        wr (0, 32'h40, 32'hFFFF_FFFF, 4'hF, 1'b1, 0);
        wr (0, 32'h02, 32'hFFFF_FFFF, 4'hF, 1'b1, 0);
        rdc(0, 32'h40, 32'h0000_0000, 1'b1, 0);
        rdc(0, 32'h00, 32'h0000_0000, 1'b0, 0);
        rdc(0, 32'h08, 32'hDE22_BE44, 1'b0, 0);
        rdc(0, 32'h3C, 32'h0000_0000, 1'b0, 0);
        idle();

        // Back-to-back writes then readback with no idle cycles.
        wr (0, 32'h00, 32'hA1A1_0001, 4'hF, 1'b0, 0);
        wr (0, 32'h04, 32'hB2B2_0002, 4'hF, 1'b0, 0);
        wr (0, 32'h08, 32'hC3C3_0003, 4'hF, 1'b0, 0);
        rdc(0, 32'h00, 32'hA1A1_0001, 1'b0, 0);
        rdc(0, 32'h04, 32'hB2B2_0002, 1'b0, 0);
        rdc(0, 32'h08, 32'hC3C3_0003, 1'b0, 0);
        idle();

        // Three wait states.
        wr (1, 32'h04, 32'hCAFE_F00D, 4'hF, 1'b0, 3);
        rdc(1, 32'h04, 32'hCAFE_F00D, 1'b0, 3);
        rdc(1, 32'h41, 32'h0000_0000, 1'b1, 3);
        idle();

        // Two wait states, then a write aborted by reset in its wait state.
        wr (2, 32'h0C, 32'h1234_5678, 4'hF, 1'b0, 2);
        rdc(2, 32'h0C, 32'h1234_5678, 1'b0, 2);
        idle();
        m_tgt = 2; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1;
        m_paddr = 32'h0C; m_pwdata = 32'h55AA_55AA; m_pstrb = 4'hF;
        @(posedge clk); #1;
        m_penable = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        m_psel = 1'b0; m_penable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        rdc(2, 32'h0C, 32'h0000_0000, 1'b0, 2);
        idle();
        repeat (2) @(posedge clk);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected: %0d completions never seen, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
